noc_rx_endpoint: RTL and testbench
==================================

Name: noc_rx_endpoint

Overview:
- Receive-side endpoint adapter for a ring/mesh router output port.
- Accepts flits under credit-based flow control (send/data/dest/is_tail in, one-cycle credit pulse out), buffers them, and presents a valid/ready stream to the attached client.
- Tracks packet framing, counts packets and flags protocol violations.
- The upstream router holds FLIT_BUFFER_DEPTH credits after reset.

Parameters:
- DEST_WIDTH, 4, width of flit destination field
- FLIT_WIDTH, 256, width of flit payload
- FLIT_BUFFER_DEPTH, 2, receive FIFO depth in flits; equals the upstream credit count after reset; must be >= 1
- PKT_CNT_WIDTH, 16, width of the delivered-packet counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- data_in  in  FLIT_WIDTH  flit payload from router output
- dest_in  in  DEST_WIDTH  flit destination
- is_tail_in  in  1  last flit of packet
- send_in  in  1  flit valid this cycle (one flit per cycle max)
- credit_out  out  1  one-cycle pulse returning one buffer slot to upstream
- out_data  out  FLIT_WIDTH  head-of-FIFO payload
- out_dest  out  DEST_WIDTH  head-of-FIFO destination
- out_is_tail  out  1  head-of-FIFO tail flag
- out_is_head  out  1  head-of-FIFO is first flit of a packet
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  client accepts flit when out_valid & out_ready
- pkt_count  out  PKT_CNT_WIDTH  tail flits delivered to client; wraps modulo 2^PKT_CNT_WIDTH
- err_overflow  out  1  sticky: send_in while FIFO full
- err_dest_mismatch  out  1  sticky: dest changed within a packet

Behaviour:
- Reset values: credit_out=0, out_valid=0, pkt_count=0, err_*=0, FIFO empty, rx state IDLE, out_is_head=1.
- Reset asserted mid-operation: all contents discarded, all state returns to reset values immediately. No credits are returned for discarded flits; upstream is reset together.
- Enqueue: on a clk edge with send_in=1 and FIFO not full, write {data,dest,is_tail} at the write pointer.
  - Flit appears on out_* with out_valid=1 the next cycle when the FIFO was empty. Enqueue-to-visible latency is 1 cycle.
- Dequeue: occurs on out_valid & out_ready. The read pointer advances.
  - credit_out is registered and pulses 1 in the cycle after the dequeue edge.
  - Exactly one credit pulse per dequeued flit; never pulse otherwise.
- Simultaneous enqueue and dequeue:
  - Occupancy is unchanged.
  - When full, a same-cycle send_in is still an overflow, because full is evaluated before the dequeue.
  - Legal upstream cannot do this, since the credit arrives a cycle later.
- Pointers wrap modulo FLIT_BUFFER_DEPTH. Occupancy counter has range 0..FLIT_BUFFER_DEPTH. Non-power-of-2 depth must work.
- Overflow: send_in=1 while full. The flit is dropped, FIFO is unchanged, err_overflow is set until reset, and no credit is generated.
- Rx framing state machine (on accepted enqueues):
  - IDLE: flit accepted. is_tail=1 stays IDLE (single-flit packet); otherwise go to IN_PKT and latch pkt_dest=dest_in.
  - IN_PKT: flit accepted. If dest_in != pkt_dest, set err_dest_mismatch (flit still stored). If is_tail=1 go to IDLE.
- out_is_head:
  - Computed from delivery-side state: 1 for the first flit after reset or after a delivered tail, else 0.
  - Stored per flit or tracked by a read-side flag; must be correct when the FIFO holds flits of two packets.
- pkt_count increments by 1 on each dequeue of a flit with out_is_tail=1 and wraps from max to 0.
- out_* values are don't-care when out_valid=0. They must be stable while out_valid=1 and out_ready=0.

Test Plan:
- Fill and drain, DEPTH=2: 2 back-to-back single-flit packets with out_ready=0. Expect out_valid=1 from cycle after the first, no credit_out, err_overflow=0. Raise out_ready for 2 cycles: expect credit_out pulses one cycle after each dequeue, pkt_count=2.
- Overflow: with FIFO full, a third send_in. Expect err_overflow=1 held, FIFO content unchanged, exactly 2 credit pulses total after draining.
- Multi-flit packet: 3 flits, dest=5, tails 0,0,1, with out_ready=1. Expect out_is_head 1,0,0, pkt_count +1 only on the third flit, and the 3 credits returned.
- Dest mismatch: head dest=3, body dest=4, tail dest=3. Expect err_dest_mismatch=1 after the body flit, all 3 flits still delivered.
- Streaming throughput: send_in=1 every cycle with out_ready=1, using a model that honours credits (2 credits, decrement on send, increment on credit_out). Expect no overflow and ≥1 flit per 2 cycles at DEPTH=2 in steady state, in order. Data pattern is incrementing.
- Reset mid-packet and wrap: assert rst with 1 flit buffered inside an IN_PKT packet. Expect out_valid=0, credit_out=0, pkt_count=0 immediately. With PKT_CNT_WIDTH=2, deliver 5 packets: expect pkt_count=1.

Source files
------------

// File: rtl/noc_rx_endpoint_if.sv
// Flit-receive and client-stream signal bundle for noc_rx_endpoint.
// The slave modport is the endpoint; master is the router/client environment.
interface noc_rx_endpoint_if #(
  parameter int unsigned DEST_WIDTH    = 4,
  parameter int unsigned FLIT_WIDTH    = 256,
  parameter int unsigned PKT_CNT_WIDTH = 16
);
  logic [FLIT_WIDTH-1:0]    data_in;
  logic [DEST_WIDTH-1:0]    dest_in;
  logic                     is_tail_in;
  logic                     send_in;
  logic                     credit_out;
  logic [FLIT_WIDTH-1:0]    out_data;
  logic [DEST_WIDTH-1:0]    out_dest;
  logic                     out_is_tail;
  logic                     out_is_head;
  logic                     out_valid;
  logic                     out_ready;
  logic [PKT_CNT_WIDTH-1:0] pkt_count;
  logic                     err_overflow;
  logic                     err_dest_mismatch;

  modport master (
    output data_in, dest_in, is_tail_in, send_in, out_ready,
    input  credit_out, out_data, out_dest, out_is_tail, out_is_head, out_valid,
           pkt_count, err_overflow, err_dest_mismatch
  );

  modport slave (
    input  data_in, dest_in, is_tail_in, send_in, out_ready,
    output credit_out, out_data, out_dest, out_is_tail, out_is_head, out_valid,
           pkt_count, err_overflow, err_dest_mismatch
  );
endinterface

// File: rtl/noc_rx_endpoint.sv
// Receive endpoint: credit-flow-controlled flit FIFO feeding a valid/ready client,
// with packet framing checks and a delivered-packet counter.
module noc_rx_endpoint #(
  parameter int unsigned DEST_WIDTH        = 4,
  parameter int unsigned FLIT_WIDTH        = 256,
  parameter int unsigned FLIT_BUFFER_DEPTH = 2,
  parameter int unsigned PKT_CNT_WIDTH     = 16
) (
  input logic             clk,
  input logic             rst,
  noc_rx_endpoint_if.slave bus
);

  localparam int unsigned PTR_W = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FLIT_BUFFER_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FLIT_BUFFER_DEPTH);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
  } flit_t;

  typedef enum logic {
    IDLE,
    IN_PKT
  } rx_state_t;

  flit_t                    mem [FLIT_BUFFER_DEPTH];
  flit_t                    head;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     valid_q;
  logic                     head_q;
  logic                     credit_q;
  logic                     err_ovf_q;
  logic                     err_dst_q;
  logic [PKT_CNT_WIDTH-1:0] pkt_q;
  rx_state_t                state;
  logic [DEST_WIDTH-1:0]    pkt_dest;
  logic                     full_c;
  logic                     push_c;
  logic                     pop_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Fullness is judged before any same-cycle dequeue, so a send while full always overflows.
  assign full_c = (count == FULL_CNT);
  assign push_c = bus.send_in & ~full_c;
  assign pop_c  = valid_q & bus.out_ready;
  assign head   = mem[rd_ptr];

  // Payload storage carries no reset; validity is tracked by count/valid_q.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{data: bus.data_in, dest: bus.dest_in, is_tail: bus.is_tail_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_q   <= 1'b0;
      head_q    <= 1'b1;
      credit_q  <= 1'b0;
      err_ovf_q <= 1'b0;
      err_dst_q <= 1'b0;
      pkt_q     <= '0;
      state     <= IDLE;
      pkt_dest  <= '0;
    end else begin
      credit_q <= pop_c;

      if (push_c) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end

      if (pop_c) begin
        rd_ptr <= ptr_inc(rd_ptr);
        head_q <= head.is_tail;
        if (head.is_tail) begin
          pkt_q <= pkt_q + PKT_CNT_WIDTH'(1);
        end
      end

      case ({push_c, pop_c})
        2'b10: begin
          count   <= count + CNT_W'(1);
          valid_q <= 1'b1;
        end
        2'b01: begin
          count   <= count - CNT_W'(1);
          valid_q <= (count != CNT_W'(1));
        end
        default: ;
      endcase

      if (bus.send_in && full_c) begin
        err_ovf_q <= 1'b1;
      end

      // Framing tracks accepted flits only; dropped flits never reach it.
      if (push_c) begin
        case (state)
          IDLE: begin
            if (!bus.is_tail_in) begin
              state    <= IN_PKT;
              pkt_dest <= bus.dest_in;
            end
          end
          IN_PKT: begin
            if (bus.dest_in != pkt_dest) begin
              err_dst_q <= 1'b1;
            end
            if (bus.is_tail_in) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.credit_out        = credit_q;
  assign bus.out_data          = head.data;
  assign bus.out_dest          = head.dest;
  assign bus.out_is_tail       = head.is_tail;
  assign bus.out_is_head       = head_q;
  assign bus.out_valid         = valid_q;
  assign bus.pkt_count         = pkt_q;
  assign bus.err_overflow      = err_ovf_q;
  assign bus.err_dest_mismatch = err_dst_q;

endmodule

// File: tb/tb_noc_rx_endpoint.sv
// Directed scoreboard bench for noc_rx_endpoint with a credit-honouring sender model.
module tb_noc_rx_endpoint;

  localparam int unsigned DW    = 4;
  localparam int unsigned FW    = 64;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned PCW   = 2;

  typedef struct packed {
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic          tail;
    logic          head;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  noc_rx_endpoint_if #(.DEST_WIDTH(DW), .FLIT_WIDTH(FW), .PKT_CNT_WIDTH(PCW)) bus ();

  noc_rx_endpoint #(
    .DEST_WIDTH(DW), .FLIT_WIDTH(FW), .FLIT_BUFFER_DEPTH(DEPTH), .PKT_CNT_WIDTH(PCW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t           sb[$];
  int             checks = 0;
  int             errors = 0;
  int             credits;
  int             credit_total;
  int             cyc = 0;
  logic [PCW-1:0] exp_pkt;
  logic           sb_head;
  logic           prev_hs = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Delivery monitor: credit timing, scoreboard compare, packet counter model.
  always @(negedge clk) begin
    if (rst) begin
      prev_hs = 1'b0;
    end else begin
      exp_t e;
      chk("credit_timing", 64'(bus.credit_out), 64'(prev_hs));
      if (bus.credit_out) begin
        credits++;
        credit_total++;
      end
      prev_hs = bus.out_valid & bus.out_ready;
      if (prev_hs) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_flit observed=%0h expected=none", bus.out_data);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e.data));
          chk("out_dest", 64'(bus.out_dest), 64'(e.dest));
          chk("out_is_tail", 64'(bus.out_is_tail), 64'(e.tail));
          chk("out_is_head", 64'(bus.out_is_head), 64'(e.head));
          chk("pkt_count_at_deq", 64'(bus.pkt_count), 64'(exp_pkt));
          if (e.tail) exp_pkt = exp_pkt + PCW'(1);
        end
      end
    end
  end

  task automatic reset_assert();
    rst            = 1'b1;
    bus.send_in    = 1'b0;
    bus.out_ready  = 1'b0;
    sb.delete();
    credits        = DEPTH;
    credit_total   = 0;
    exp_pkt        = '0;
    sb_head        = 1'b1;
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [FW-1:0] d, input logic [DW-1:0] dst, input logic tail,
                      input bit expect_drop);
    int n = 0;
    while (!expect_drop && credits == 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $error("FAIL credit_wait observed=no credit expected=credit within 100 cycles");
    end
    bus.data_in    = d;
    bus.dest_in    = dst;
    bus.is_tail_in = tail;
    bus.send_in    = 1'b1;
    if (!expect_drop) begin
      credits--;
      sb.push_back('{data: d, dest: dst, tail: tail, head: sb_head});
      sb_head = tail;
    end
    @(posedge clk);
    #1;
    bus.send_in = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d pending expected=0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    bus.data_in    = '0;
    bus.dest_in    = '0;
    bus.is_tail_in = 1'b0;
    reset_assert();
    reset_release();

    // Reset values
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_credit_out", 64'(bus.credit_out), 64'(0));
    chk("rst_pkt_count", 64'(bus.pkt_count), 64'(0));
    chk("rst_err_overflow", 64'(bus.err_overflow), 64'(0));
    chk("rst_err_dest", 64'(bus.err_dest_mismatch), 64'(0));
    chk("rst_out_is_head", 64'(bus.out_is_head), 64'(1));

    // Fill with client stalled, then overflow
    send(64'hA0, 4'd1, 1'b1, 1'b0);
    chk("fill_valid_after_first", 64'(bus.out_valid), 64'(1));
    chk("fill_head_data", 64'(bus.out_data), 64'hA0);
    send(64'hB1, 4'd2, 1'b1, 1'b0);
    chk("fill_no_credit", 64'(credit_total), 64'(0));
    chk("fill_no_overflow", 64'(bus.err_overflow), 64'(0));
    send(64'hC2, 4'd3, 1'b1, 1'b1);
    chk("ovf_flag", 64'(bus.err_overflow), 64'(1));
    chk("ovf_head_unchanged", 64'(bus.out_data), 64'hA0);
    chk("ovf_still_valid", 64'(bus.out_valid), 64'(1));
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 64'(bus.out_valid), 64'(0));
    chk("drain_pkt_count", 64'(bus.pkt_count), 64'(2));
    chk("drain_credit_total", 64'(credit_total), 64'(2));
    chk("drain_sb_empty", 64'(sb.size()), 64'(0));
    chk("ovf_sticky", 64'(bus.err_overflow), 64'(1));

    // Multi-flit packet, client always ready
    reset_assert();
    reset_release();
    bus.out_ready = 1'b1;
    send(64'h100, 4'd5, 1'b0, 1'b0);
    send(64'h101, 4'd5, 1'b0, 1'b0);
    send(64'h102, 4'd5, 1'b1, 1'b0);
    drain(50);
    chk("multi_pkt_count", 64'(bus.pkt_count), 64'(1));
    chk("multi_credit_total", 64'(credit_total), 64'(3));
    chk("multi_no_dest_err", 64'(bus.err_dest_mismatch), 64'(0));

    // Destination change inside a packet
    reset_assert();
    reset_release();
    bus.out_ready = 1'b1;
    send(64'h200, 4'd3, 1'b0, 1'b0);
    chk("dest_head_ok", 64'(bus.err_dest_mismatch), 64'(0));
    send(64'h201, 4'd4, 1'b0, 1'b0);
    chk("dest_mismatch_set", 64'(bus.err_dest_mismatch), 64'(1));
    send(64'h202, 4'd3, 1'b1, 1'b0);
    drain(50);
    chk("dest_mismatch_sticky", 64'(bus.err_dest_mismatch), 64'(1));
    chk("dest_credit_total", 64'(credit_total), 64'(3));
    chk("dest_pkt_count", 64'(bus.pkt_count), 64'(1));

    // Reset with one flit buffered mid-packet; pkt_count and err are non-zero beforehand
    bus.out_ready = 1'b0;
    send(64'h300, 4'd7, 1'b0, 1'b0);
    chk("mid_valid_before_rst", 64'(bus.out_valid), 64'(1));
    reset_assert();
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_credit", 64'(bus.credit_out), 64'(0));
    chk("mid_rst_pkt_count", 64'(bus.pkt_count), 64'(0));
    chk("mid_rst_err_dest", 64'(bus.err_dest_mismatch), 64'(0));
    chk("mid_rst_is_head", 64'(bus.out_is_head), 64'(1));
    reset_release();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_discarded", 64'(bus.out_valid), 64'(0));
    for (int i = 0; i < 5; i++) begin
      send(64'(64'h400 + i), 4'd2, 1'b1, 1'b0);
    end
    drain(50);
    chk("wrap_pkt_count", 64'(bus.pkt_count), 64'(1));
    chk("wrap_no_dest_err", 64'(bus.err_dest_mismatch), 64'(0));
    chk("wrap_credit_total", 64'(credit_total), 64'(5));

    // Credit-honouring streaming, incrementing data
    reset_assert();
    reset_release();
    bus.out_ready = 1'b1;
    start = cyc;
    for (int i = 0; i < 24; i++) begin
      send(64'(i), 4'(i), 1'b1, 1'b0);
    end
    drain(100);
    chk("stream_rate", 64'((cyc - start) <= 2 * 24 + 4), 64'(1));
    chk("stream_no_overflow", 64'(bus.err_overflow), 64'(0));
    chk("stream_credits_back", 64'(credits), 64'(DEPTH));
    chk("stream_pkt_count", 64'(bus.pkt_count), 64'(24 % 4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
